// File: rtl/alu_pkg.sv
// Shared types and helpers for the multi-cycle add/subtract unit.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int unsigned n_chunks(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple-carry adder; also exposes the carry into its top bit.
module adder_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout     = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/addsub_multicycle.sv
// WIDTH-bit add/subtract computed CHUNK bits per clock, carry rippled between cycles.
module addsub_multicycle
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cf,
  output logic             sf,
  output logic             zf,
  output logic             of
);

  localparam int unsigned NCHUNK = n_chunks(WIDTH, CHUNK);
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_r, b_r, res_r, res_full;
  logic             carry, op_r;
  logic [IDXW-1:0]  idx;
  logic [CHUNK-1:0] a_c, b_c, sum_c;
  logic             cout_c, cmsb_c;
  logic             accept, last;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (state == RUN) && (idx == LAST);

  // Constant-slice selection keeps every index in range, including WIDTH == CHUNK.
  always_comb begin
    a_c      = '0;
    b_c      = '0;
    res_full = res_r;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (idx == IDXW'(i)) begin
        a_c = a_r[i*CHUNK +: CHUNK];
        b_c = b_r[i*CHUNK +: CHUNK];
        res_full[i*CHUNK +: CHUNK] = sum_c;
      end
    end
  end

  adder_chunk #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .a        (a_c),
    .b        (b_c),
    .cin      (carry),
    .sum      (sum_c),
    .cout     (cout_c),
    .c_msb_in (cmsb_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (idx == LAST) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      res_r <= '0;
      carry <= 1'b0;
      op_r  <= OP_ADD;
      idx   <= '0;
      s     <= '0;
      cf    <= 1'b0;
      sf    <= 1'b0;
      zf    <= 1'b0;
      of    <= 1'b0;
    end else if (accept) begin
      a_r   <= a;
      b_r   <= (op == OP_SUB) ? ~b : b;
      carry <= (op == OP_SUB) ? ~cin : cin;
      op_r  <= op;
      idx   <= '0;
      res_r <= '0;
    end else if (state == RUN) begin
      res_r <= res_full;
      carry <= cout_c;
      if (last) begin
        s  <= res_full;
        cf <= cout_c ^ op_r;
        sf <= res_full[WIDTH-1];
        zf <= (res_full == '0);
        of <= cmsb_c ^ cout_c;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_addsub_multicycle.sv
// Directed and model-checked stimulus for addsub_multicycle at three parameter points.
module tb_addsub_multicycle;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // DUT 0: WIDTH=16 CHUNK=4
  logic        iv0 = 0, op0 = 0, ci0 = 0, or0 = 0;
  logic [15:0] a0 = '0, b0 = '0;
  logic        ir0, ov0, cf0, sf0, zf0, of0;
  logic [15:0] s0;
  // DUT 1: WIDTH=5 CHUNK=1
  logic        iv1 = 0, op1 = 0, ci1 = 0, or1 = 0;
  logic [4:0]  a1 = '0, b1 = '0;
  logic        ir1, ov1, cf1, sf1, zf1, of1;
  logic [4:0]  s1;
  // DUT 2: WIDTH=8 CHUNK=8
  logic        iv2 = 0, op2 = 0, ci2 = 0, or2 = 0;
  logic [7:0]  a2 = '0, b2 = '0;
  logic        ir2, ov2, cf2, sf2, zf2, of2;
  logic [7:0]  s2;

  addsub_multicycle #(.WIDTH(16), .CHUNK(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .op(op0), .a(a0), .b(b0),
    .cin(ci0), .out_valid(ov0), .out_ready(or0), .s(s0), .cf(cf0), .sf(sf0), .zf(zf0), .of(of0));
  addsub_multicycle #(.WIDTH(5), .CHUNK(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .op(op1), .a(a1), .b(b1),
    .cin(ci1), .out_valid(ov1), .out_ready(or1), .s(s1), .cf(cf1), .sf(sf1), .zf(zf1), .of(of1));
  addsub_multicycle #(.WIDTH(8), .CHUNK(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .op(op2), .a(a2), .b(b2),
    .cin(ci2), .out_valid(ov2), .out_ready(or2), .s(s2), .cf(cf2), .sf(sf2), .zf(zf2), .of(of2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_ir(input int k);
    case (k) 0: return ir0; 1: return ir1; default: return ir2; endcase
  endfunction

  function automatic logic get_ov(input int k);
    case (k) 0: return ov0; 1: return ov1; default: return ov2; endcase
  endfunction

  function automatic logic [15:0] get_s(input int k);
    case (k) 0: return s0; 1: return {11'd0, s1}; default: return {8'd0, s2}; endcase
  endfunction

  function automatic logic [3:0] get_fl(input int k);
    case (k)
      0:       return {cf0, sf0, zf0, of0};
      1:       return {cf1, sf1, zf1, of1};
      default: return {cf2, sf2, zf2, of2};
    endcase
  endfunction

  task automatic set_in(input int k, input logic v, input logic op, input logic [15:0] a,
                        input logic [15:0] b, input logic cin);
    case (k)
      0:       begin iv0 = v; op0 = op; a0 = a; b0 = b; ci0 = cin; end
      1:       begin iv1 = v; op1 = op; a1 = a[4:0]; b1 = b[4:0]; ci1 = cin; end
      default: begin iv2 = v; op2 = op; a2 = a[7:0]; b2 = b[7:0]; ci2 = cin; end
    endcase
  endtask

  task automatic set_or(input int k, input logic r);
    case (k) 0: or0 = r; 1: or1 = r; default: or2 = r; endcase
  endtask

  // Issue one op, wait (bounded) for the result, then consume it.
  task automatic do_op(input int k, input logic op, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, output logic [15:0] s, output logic [3:0] fl,
                       output int lat);
    chk("ready_idle", 32'(get_ir(k)), 32'd1);
    set_in(k, 1'b1, op, a, b, cin);
    tick();
    set_in(k, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
    lat = 0;
    while (!get_ov(k) && lat < 64) begin
      chk("ready_busy", 32'(get_ir(k)), 32'd0);
      tick();
      lat++;
    end
    chk("ready_done", 32'(get_ir(k)), 32'd0);
    s  = get_s(k);
    fl = get_fl(k);
    set_or(k, 1'b1);
    tick();
    set_or(k, 1'b0);
  endtask

  // Reference arithmetic on integers: flags from true unsigned/signed results.
  task automatic model(input int w, input logic op, input longint a, input longint b,
                       input logic cin, output logic [15:0] s, output logic [3:0] fl);
    longint full, sa, sb, sr, lim;
    logic   cf, sf, zf, of;
    lim = longint'(1) << (w - 1);
    sa  = (a >= lim) ? a - 2 * lim : a;
    sb  = (b >= lim) ? b - 2 * lim : b;
    if (op == 1'b0) begin
      full = a + b + longint'(cin);
      cf   = (full >= 2 * lim);
      sr   = sa + sb + longint'(cin);
    end else begin
      full = a - b - longint'(cin);
      cf   = (full < 0);
      sr   = sa - sb - longint'(cin);
    end
    full = full & (2 * lim - 1);
    s    = 16'(full);
    sf   = (full >= lim);
    zf   = (full == 0);
    of   = (sr >= lim) || (sr < -lim);
    fl   = {cf, sf, zf, of};
  endtask

  initial begin
    logic [15:0] rs, ms;
    logic [3:0]  rf, mf;
    int          lat;
    logic        rop, rcin;
    logic [15:0] ra, rb, mask;

    // Reset
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_out_valid", 32'(ov0), 32'd0);
    chk("rst_in_ready", 32'(ir0), 32'd1);
    chk("rst_s", 32'(s0), 32'd0);
    chk("rst_flags", 32'(get_fl(0)), 32'd0);

    // Directed add/sub vectors, flags packed {cf,sf,zf,of}
    do_op(0, 1'b0, 16'h1234, 16'h4321, 1'b0, rs, rf, lat);
    chk("add1_lat", 32'(lat), 32'd4);
    chk("add1_s", 32'(rs), 32'h5555);
    chk("add1_fl", 32'(rf), 32'b0000);

    do_op(0, 1'b0, 16'hFFFF, 16'h0001, 1'b0, rs, rf, lat);
    chk("add_wrap_s", 32'(rs), 32'h0000);
    chk("add_wrap_fl", 32'(rf), 32'b1010);

    do_op(0, 1'b0, 16'h7FFF, 16'h0001, 1'b0, rs, rf, lat);
    chk("add_ovf_s", 32'(rs), 32'h8000);
    chk("add_ovf_fl", 32'(rf), 32'b0101);

    do_op(0, 1'b1, 16'h0003, 16'h0005, 1'b0, rs, rf, lat);
    chk("sub_neg_s", 32'(rs), 32'hFFFE);
    chk("sub_neg_fl", 32'(rf), 32'b1100);

    do_op(0, 1'b1, 16'h8000, 16'h0001, 1'b0, rs, rf, lat);
    chk("sub_ovf_s", 32'(rs), 32'h7FFF);
    chk("sub_ovf_fl", 32'(rf), 32'b0001);

    do_op(0, 1'b1, 16'h0005, 16'h0002, 1'b1, rs, rf, lat);
    chk("sub_bin_s", 32'(rs), 32'h0002);
    chk("sub_bin_fl", 32'(rf), 32'b0000);
    chk("idle_hold_s", 32'(s0), 32'h0002);

    // Backpressure in DONE with new operands offered
    set_in(0, 1'b1, 1'b0, 16'h1111, 16'h2222, 1'b0);
    tick();
    set_in(0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
    lat = 0;
    while (!ov0 && lat < 64) begin tick(); lat++; end
    chk("bp_lat", 32'(lat), 32'd4);
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1'b1, 1'b1, 16'hAAAA, 16'h5555, 1'b1);
      tick();
      chk("bp_valid", 32'(ov0), 32'd1);
      chk("bp_ready", 32'(ir0), 32'd0);
      chk("bp_s", 32'(s0), 32'h3333);
      chk("bp_fl", 32'(get_fl(0)), 32'b0000);
    end
    set_in(0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
    set_or(0, 1'b1);
    tick();
    set_or(0, 1'b0);
    chk("bp_rel_valid", 32'(ov0), 32'd0);
    chk("bp_rel_ready", 32'(ir0), 32'd1);
    chk("bp_rel_s", 32'(s0), 32'h3333);
    tick();
    chk("bp_no_queue", 32'(ir0), 32'd1);

    // Reset after two RUN cycles
    set_in(0, 1'b1, 1'b0, 16'h0F0F, 16'h0101, 1'b0);
    tick();
    set_in(0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_valid", 32'(ov0), 32'd0);
    chk("mid_rst_ready", 32'(ir0), 32'd1);
    chk("mid_rst_s", 32'(s0), 32'd0);
    chk("mid_rst_fl", 32'(get_fl(0)), 32'd0);
    do_op(0, 1'b0, 16'h0001, 16'h0001, 1'b0, rs, rf, lat);
    chk("post_rst_lat", 32'(lat), 32'd4);
    chk("post_rst_s", 32'(rs), 32'h0002);
    chk("post_rst_fl", 32'(rf), 32'b0000);

    // Parameter sweep against the integer model
    for (int k = 1; k <= 2; k++) begin
      mask = (k == 1) ? 16'h001F : 16'h00FF;
      for (int n = 0; n < 1000; n++) begin
        rop  = 1'($urandom_range(0, 1));
        rcin = 1'($urandom_range(0, 1));
        ra   = 16'($urandom) & mask;
        rb   = 16'($urandom) & mask;
        model((k == 1) ? 5 : 8, rop, longint'(ra), longint'(rb), rcin, ms, mf);
        do_op(k, rop, ra, rb, rcin, rs, rf, lat);
        chk((k == 1) ? "w5_lat" : "w8_lat", 32'(lat), (k == 1) ? 32'd5 : 32'd1);
        chk((k == 1) ? "w5_s" : "w8_s", 32'(rs), 32'(ms));
        chk((k == 1) ? "w5_fl" : "w8_fl", 32'(rf), 32'(mf));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
